// File: rtl/sram_bus_pkg.sv
// Shared types and constants for the SRAM bus slave model: FSM encoding,
// wait-counter width, read-data source select and the byte-lane helper.
package sram_bus_pkg;

  localparam int CNT_W = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // Which value rdata presents between acks.
  typedef enum logic [1:0] {
    RSEL_ZERO = 2'd0,
    RSEL_MEM  = 2'd1,
    RSEL_ONES = 2'd2
  } rsel_t;

  function automatic int lane_count(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/sram_array.sv
// Word-wide storage with a byte-enabled synchronous write port and a
// registered read port that holds its value between reads.
// Contents are never cleared by reset.
module sram_array
  import sram_bus_pkg::*;
#(
  parameter int    DATA_W    = 16,
  parameter int    DEPTH     = 1024,
  parameter string INIT_FILE = "",
  parameter int    IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                          clk,
  input  logic                          wr_en,
  input  logic [IDX_W-1:0]              wr_idx,
  input  logic [lane_count(DATA_W)-1:0] wr_be,
  input  logic [DATA_W-1:0]             wr_dat,
  input  logic                          rd_en,
  input  logic [IDX_W-1:0]              rd_idx,
  output logic [DATA_W-1:0]             rd_dat
);

  localparam int LANES = lane_count(DATA_W);

  reg [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < LANES; i++) begin
        if (wr_be[i]) mem[wr_idx][8*i +: 8] <= wr_dat[8*i +: 8];
      end
    end
    if (rd_en) rd_dat <= mem[rd_idx];
  end

endmodule

// File: rtl/sram_bus_model.sv
// Request/acknowledge bus slave standing in for the system SRAM: latches a
// request in IDLE, counts out the wait states, then performs the access.
module sram_bus_model
  import sram_bus_pkg::*;
#(
  parameter int    ADDR_W    = 17,
  parameter int    DATA_W    = 16,
  parameter int    DEPTH     = 1024,
  parameter int    RD_WAIT   = 2,
  parameter int    WR_WAIT   = 2,
  parameter string INIT_FILE = ""
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req,
  input  logic                          we,
  input  logic [ADDR_W-1:0]             addr,
  input  logic [lane_count(DATA_W)-1:0] be,
  input  logic [DATA_W-1:0]             wdata,
  output logic [DATA_W-1:0]             rdata,
  output logic                          ack,
  output logic                          err,
  output logic                          busy
);

  localparam int LANES = lane_count(DATA_W);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0]  RD_CNT  = CNT_W'(RD_WAIT);
  localparam logic [CNT_W-1:0]  WR_CNT  = CNT_W'(WR_WAIT);
  localparam logic [ADDR_W:0]   DEPTH_V = (ADDR_W+1)'(DEPTH);

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  rsel_t              rsel;
  logic               accept, access;

  logic               we_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [LANES-1:0]   be_q;
  logic [DATA_W-1:0]  wdata_q;

  logic               in_range;
  logic [DATA_W-1:0]  arr_dat;

  // Range check on the full address so high addresses never alias into the array.
  assign in_range = ({1'b0, addr_q} < DEPTH_V);
  assign busy     = (state != ST_IDLE);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    accept   = 1'b0;
    access   = 1'b0;
    case (state)
      ST_IDLE: begin
        // An X on req falls through to the idle branch and is ignored.
        if (req == 1'b1) begin
          accept   = 1'b1;
          state_nx = ST_WAIT;
          cnt_nx   = we ? WR_CNT : RD_CNT;
        end
      end
      ST_WAIT: begin
        if (cnt != '0) begin
          cnt_nx = cnt - 1'b1;
        end else begin
          access   = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      ack   <= 1'b0;
      err   <= 1'b0;
      rsel  <= RSEL_ZERO;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      ack   <= access;
      err   <= access & ~in_range;
      if (access && !we_q) rsel <= in_range ? RSEL_MEM : RSEL_ONES;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= we;
      addr_q  <= addr;
      be_q    <= be;
      wdata_q <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    case (rsel)
      RSEL_MEM:  rdata = arr_dat;
      RSEL_ONES: rdata = '1;
      default:   rdata = '0;
    endcase
  end

  // rst_n gates the write so a reset on the access edge abandons the write.
  sram_array #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .INIT_FILE (INIT_FILE),
    .IDX_W     (IDX_W)
  ) u_array (
    .clk    (clk),
    .wr_en  (access & we_q & in_range & rst_n),
    .wr_idx (addr_q[IDX_W-1:0]),
    .wr_be  (be_q),
    .wr_dat (wdata_q),
    .rd_en  (access & ~we_q & in_range & rst_n),
    .rd_idx (addr_q[IDX_W-1:0]),
    .rd_dat (arr_dat)
  );

endmodule

// File: tb/tb_sram_bus_model.sv
// Directed bench for sram_bus_model: three instances with different wait
// settings, expected results queued at request time and checked on ack.
module tb_sram_bus_model;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req   [3];
  logic        we    [3];
  logic [16:0] addr  [3];
  logic [1:0]  be    [3];
  logic [15:0] wdata [3];
  logic [15:0] rdata [3];
  logic        ack   [3];
  logic        err   [3];
  logic        busy  [3];

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    bit          rd;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  sram_bus_model #(.ADDR_W(17), .DATA_W(16), .DEPTH(1024), .RD_WAIT(2), .WR_WAIT(2), .INIT_FILE("")) u0 (
    .clk(clk), .rst_n(rst_n), .req(req[0]), .we(we[0]), .addr(addr[0]), .be(be[0]),
    .wdata(wdata[0]), .rdata(rdata[0]), .ack(ack[0]), .err(err[0]), .busy(busy[0]));

  sram_bus_model #(.ADDR_W(17), .DATA_W(16), .DEPTH(1024), .RD_WAIT(0), .WR_WAIT(0), .INIT_FILE("")) u1 (
    .clk(clk), .rst_n(rst_n), .req(req[1]), .we(we[1]), .addr(addr[1]), .be(be[1]),
    .wdata(wdata[1]), .rdata(rdata[1]), .ack(ack[1]), .err(err[1]), .busy(busy[1]));

  sram_bus_model #(.ADDR_W(17), .DATA_W(16), .DEPTH(1024), .RD_WAIT(5), .WR_WAIT(0), .INIT_FILE("")) u2 (
    .clk(clk), .rst_n(rst_n), .req(req[2]), .we(we[2]), .addr(addr[2]), .be(be[2]),
    .wdata(wdata[2]), .rdata(rdata[2]), .ack(ack[2]), .err(err[2]), .busy(busy[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete access; returns with time at #1 after the edge following ack.
  task automatic do_access(input int d, input bit w, input logic [16:0] a, input logic [1:0] b,
                           input logic [15:0] wd, input logic [15:0] er, input bit ee, input int lat);
    exp_t e;
    int   n;
    bit   bz;
    @(negedge clk);
    req[d] = 1'b1; we[d] = w; addr[d] = a; be[d] = b; wdata[d] = wd;
    e.rdata = er; e.err = ee; e.rd = !w; e.lat = lat;
    sb.push_back(e);
    @(posedge clk); #1;
    req[d] = 1'b0;
    n  = 0;
    bz = 1'b1;
    while (ack[d] !== 1'b1 && n < 40) begin
      bz &= (busy[d] === 1'b1);
      @(posedge clk); #1;
      n++;
    end
    e = sb.pop_front();
    chk($sformatf("latency_u%0d_a%0h", d, a), n, e.lat);
    chk($sformatf("busy_held_u%0d_a%0h", d, a), bz, 1'b1);
    chk($sformatf("busy_at_ack_u%0d", d), busy[d], 1'b0);
    if (e.rd) chk($sformatf("rdata_u%0d_a%0h", d, a), rdata[d], e.rdata);
    chk($sformatf("err_u%0d_a%0h", d, a), err[d], e.err);
    @(posedge clk); #1;
    chk($sformatf("ack_pulse_u%0d", d), ack[d], 1'b0);
  endtask

  initial begin
    exp_t e;
    int   last;
    int   nack;
    int   extra;

    for (int i = 0; i < 3; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; be[i] = '0; wdata[i] = '0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_ack_u%0d", i), ack[i], 1'b0);
      chk($sformatf("rst_err_u%0d", i), err[i], 1'b0);
      chk($sformatf("rst_busy_u%0d", i), busy[i], 1'b0);
      chk($sformatf("rst_rdata_u%0d", i), rdata[i], 16'h0000);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Write then read, full and partial byte enables
    do_access(0, 1'b1, 17'h0, 2'b11, 16'hA5F0, 16'h0, 1'b0, 3);
    do_access(0, 1'b0, 17'h0, 2'b11, 16'h0,    16'hA5F0, 1'b0, 3);
    do_access(0, 1'b1, 17'h0, 2'b01, 16'h1234, 16'h0, 1'b0, 3);
    do_access(0, 1'b0, 17'h0, 2'b00, 16'h0,    16'hA534, 1'b0, 3);
    do_access(0, 1'b1, 17'h0, 2'b00, 16'hFFFF, 16'h0, 1'b0, 3);
    do_access(0, 1'b0, 17'h0, 2'b11, 16'h0,    16'hA534, 1'b0, 3);

    // Out of range: no write, all-ones read, no aliasing onto word 0
    do_access(0, 1'b1, 17'h400,   2'b11, 16'hBEEF, 16'h0,    1'b1, 3);
    do_access(0, 1'b0, 17'h400,   2'b11, 16'h0,    16'hFFFF, 1'b1, 3);
    do_access(0, 1'b0, 17'h0,     2'b11, 16'h0,    16'hA534, 1'b0, 3);
    do_access(0, 1'b0, 17'h1FFFF, 2'b11, 16'h0,    16'hFFFF, 1'b1, 3);

    // Reset during an in-flight write abandons it
    do_access(0, 1'b1, 17'h3, 2'b11, 16'h0003, 16'h0, 1'b0, 3);
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 17'h3; be[0] = 2'b11; wdata[0] = 16'h5555;
    @(posedge clk); #1;
    req[0] = 1'b0;
    chk("mid_busy_before_rst", busy[0], 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_ack", ack[0], 1'b0);
    chk("mid_rst_busy", busy[0], 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ack[0] === 1'b1) extra++;
    end
    chk("mid_rst_no_ack", extra, 0);
    do_access(0, 1'b0, 17'h3, 2'b11, 16'h0, 16'h0003, 1'b0, 3);

    // Back-to-back reads with zero read wait
    for (int i = 0; i < 4; i++)
      do_access(1, 1'b1, 17'(i), 2'b11, 16'h1000 + 16'(i), 16'h0, 1'b0, 1);
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 17'h0; be[1] = 2'b11;
    e.rdata = 16'h1000; e.err = 1'b0; e.rd = 1'b1; e.lat = 1;
    sb.push_back(e);
    @(posedge clk);
    last = 0;
    nack = 0;
    for (int t = 1; t <= 40 && nack < 4; t++) begin
      @(posedge clk); #1;
      if (ack[1] === 1'b1) begin
        e = sb.pop_front();
        nack++;
        chk($sformatf("b2b_gap_%0d", nack), t - last, (nack == 1) ? 1 : 2);
        last = t;
        chk($sformatf("b2b_rdata_%0d", nack), rdata[1], e.rdata);
        chk($sformatf("b2b_err_%0d", nack), err[1], e.err);
        if (nack < 4) begin
          req[1]  = 1'b1;
          addr[1] = 17'(nack);
          e.rdata = 16'h1000 + 16'(nack);
          sb.push_back(e);
        end else begin
          req[1] = 1'b0;
        end
      end else if (nack % 2 == 1) begin
        // Drop req while busy on alternate accesses; it must not matter.
        req[1] = 1'b0;
      end
    end
    chk("b2b_count", nack, 4);
    extra = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ack[1] === 1'b1) extra++;
    end
    chk("b2b_no_extra_ack", extra, 0);

    // Asymmetric waits
    do_access(2, 1'b1, 17'h7, 2'b11, 16'h7777, 16'h0,    1'b0, 1);
    do_access(2, 1'b0, 17'h7, 2'b11, 16'h0,    16'h7777, 1'b0, 6);
    do_access(2, 1'b1, 17'h7, 2'b10, 16'h1200, 16'h0,    1'b0, 1);
    do_access(2, 1'b0, 17'h7, 2'b11, 16'h0,    16'h1277, 1'b0, 6);

    chk("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
